// File: rtl/fpu_op_sequencer.sv
// Purpose : sequences one FPU operation per software start. It latches the operands and
//           opcode, launches the core, waits for done, and returns the result and flags.
// Latency : legal op gives its result 2+ cycles after start (done-driven); an illegal op gives it 1 cycle after start.
// Backpr. : no stall path; a start while busy is dropped and the sticky overrun flag is set.
// Ports   : CLK/RSTN (async active-low); start/OP1/OP2/OP_select from the register bank;
//           fpu_start/fpu_op1/fpu_op2/fpu_op to the core, fpu_result/fpu_done/fpu_zero/inf/nan back;
//           Result_Fpu/Result_FPU_valid/zero_flag/INF_flag/NAN_flag, busy, overrun, timeout_err, done_irq.
// Option  : define FPU_SEQ_TIMEOUT_EN to bound WAIT to TIMEOUT_CYCLES cycles.
module fpu_op_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MEM_WIDTH      = 32
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 start,
  input  logic [MEM_WIDTH-1:0] OP1,
  input  logic [MEM_WIDTH-1:0] OP2,
  input  logic [2:0]           OP_select,
  output logic                 fpu_start,
  output logic [MEM_WIDTH-1:0] fpu_op1,
  output logic [MEM_WIDTH-1:0] fpu_op2,
  output logic [2:0]           fpu_op,
  input  logic [MEM_WIDTH-1:0] fpu_result,
  input  logic                 fpu_done,
  input  logic                 fpu_zero,
  input  logic                 fpu_inf,
  input  logic                 fpu_nan,
  output logic [MEM_WIDTH-1:0] Result_Fpu,
  output logic                 Result_FPU_valid,
  output logic                 zero_flag,
  output logic                 INF_flag,
  output logic                 NAN_flag,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout_err,
  output logic                 done_irq
);

  localparam logic [MEM_WIDTH-1:0] QNAN = MEM_WIDTH'(32'h7FC0_0000);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [MEM_WIDTH-1:0]   op1_q, op1_d, op2_q, op2_d, result_q, result_d;
  logic [2:0]             op_q, op_d;
  logic                   valid_q, valid_d, zero_q, zero_d, inf_q, inf_d, nan_q, nan_d;
  logic                   overrun_q, overrun_d, timeout_q, timeout_d, irq_q, irq_d;

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    op_d      = op_q;
    result_d  = result_q;
    valid_d   = valid_q;
    zero_d    = zero_q;
    inf_d     = inf_q;
    nan_d     = nan_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    irq_d     = 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (OP_select <= 3'd4) begin
            op1_d     = OP1;
            op2_d     = OP2;
            op_d      = OP_select;
            valid_d   = 1'b0;
            zero_d    = 1'b0;
            inf_d     = 1'b0;
            nan_d     = 1'b0;
            overrun_d = 1'b0;
            timeout_d = 1'b0;
            state_d   = S_LAUNCH;
          end else begin
            // Illegal opcode: answer with a quiet NaN and never touch the core.
            result_d = QNAN;
            zero_d   = 1'b0;
            inf_d    = 1'b0;
            nan_d    = 1'b1;
            valid_d  = 1'b1;
            irq_d    = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        if (start) overrun_d = 1'b1;
        state_d = S_WAIT;
`ifdef FPU_SEQ_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (start) overrun_d = 1'b1;
        // done takes priority over an expiry in the same cycle.
        if (fpu_done) begin
          result_d = fpu_result;
          zero_d   = fpu_zero;
          inf_d    = fpu_inf;
          nan_d    = fpu_nan;
          valid_d  = 1'b1;
          irq_d    = 1'b1;
          state_d  = S_IDLE;
        end
`ifdef FPU_SEQ_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          result_d  = QNAN;
          zero_d    = 1'b0;
          inf_d     = 1'b0;
          nan_d     = 1'b1;
          valid_d   = 1'b1;
          timeout_d = 1'b1;
          irq_d     = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      op1_q     <= '0;
      op2_q     <= '0;
      op_q      <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      zero_q    <= 1'b0;
      inf_q     <= 1'b0;
      nan_q     <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      op_q      <= op_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      zero_q    <= zero_d;
      inf_q     <= inf_d;
      nan_q     <= nan_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      irq_q     <= irq_d;
    end
  end

`ifdef FPU_SEQ_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
  assign timeout_err = timeout_q;
`else
  // Without the timeout option the parameter has no effect and the sticky bit is never set.
  logic timeout_cfg_unused;
  assign timeout_cfg_unused = (TIMEOUT_CYCLES > 0) | timeout_q;
  assign timeout_err        = 1'b0;
`endif

  assign fpu_start        = (state_q == S_LAUNCH);
  assign busy             = (state_q != S_IDLE);
  assign fpu_op1          = op1_q;
  assign fpu_op2          = op2_q;
  assign fpu_op           = op_q;
  assign Result_Fpu       = result_q;
  assign Result_FPU_valid = valid_q;
  assign zero_flag        = zero_q;
  assign INF_flag         = inf_q;
  assign NAN_flag         = nan_q;
  assign overrun          = overrun_q;
  assign done_irq         = irq_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Purpose : self-checking bench for fpu_op_sequencer with a result scoreboard.
// Latency : drives the core side by hand with fixed reply gaps.
// Backpr. : none; the bench exercises start-while-busy directly.
module tb_fpu_op_sequencer;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        start = 1'b0;
  logic [31:0] OP1 = '0, OP2 = '0;
  logic [2:0]  OP_select = '0;
  logic        fpu_start;
  logic [31:0] fpu_op1, fpu_op2;
  logic [2:0]  fpu_op;
  logic [31:0] fpu_result = '0;
  logic        fpu_done = 1'b0, fpu_zero = 1'b0, fpu_inf = 1'b0, fpu_nan = 1'b0;
  logic [31:0] Result_Fpu;
  logic        Result_FPU_valid, zero_flag, INF_flag, NAN_flag;
  logic        busy, overrun, timeout_err, done_irq;

  fpu_op_sequencer #(.TIMEOUT_CYCLES(8), .MEM_WIDTH(32)) dut (
    .CLK(CLK), .RSTN(RSTN), .start(start), .OP1(OP1), .OP2(OP2), .OP_select(OP_select),
    .fpu_start(fpu_start), .fpu_op1(fpu_op1), .fpu_op2(fpu_op2), .fpu_op(fpu_op),
    .fpu_result(fpu_result), .fpu_done(fpu_done), .fpu_zero(fpu_zero), .fpu_inf(fpu_inf),
    .fpu_nan(fpu_nan), .Result_Fpu(Result_Fpu), .Result_FPU_valid(Result_FPU_valid),
    .zero_flag(zero_flag), .INF_flag(INF_flag), .NAN_flag(NAN_flag), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err), .done_irq(done_irq)
  );

  always #5 CLK = ~CLK;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;
  int fs_cnt   = 0;
  int irq_cnt  = 0;
  logic [34:0] exp_q[$];   // {result, zero, inf, nan}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    logic [34:0] e;
    if (busy) busy_cnt++;
    if (fpu_start) fs_cnt++;
    if (done_irq) begin
      irq_cnt++;
      if (exp_q.size() == 0) begin
        check("irq_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", 64'(Result_Fpu), 64'(e[34:3]));
        check("sb_flags", 64'({zero_flag, INF_flag, NAN_flag}), 64'(e[2:0]));
        check("sb_valid", 64'(Result_FPU_valid), 64'd1);
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    OP1 = a; OP2 = b; OP_select = op; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic reply(input int gap, input logic [31:0] res, input logic z, input logic i, input logic n);
    repeat (gap) tick();
    fpu_done = 1'b1; fpu_result = res; fpu_zero = z; fpu_inf = i; fpu_nan = n;
    exp_q.push_back({res, z, i, n});
    tick();
    fpu_done = 1'b0; fpu_zero = 1'b0; fpu_inf = 1'b0; fpu_nan = 1'b0;
  endtask

  initial begin
    int b0, f0, i0;
    // Reset state
    #12;
    check("reset_outputs",
          64'({fpu_start, busy, Result_FPU_valid, zero_flag, INF_flag, NAN_flag, overrun, timeout_err, done_irq}),
          64'd0);
    check("reset_result", 64'(Result_Fpu), 64'd0);
    check("reset_ops", 64'({fpu_op1, fpu_op, fpu_op2[28:0]}), 64'd0);
    RSTN = 1'b1;
    tick();

    // Legal add: reply 3 cycles after fpu_start, busy 4 cycles
    b0 = busy_cnt; f0 = fs_cnt; i0 = irq_cnt;
    pulse_start(32'h3F80_0000, 32'h4000_0000, 3'd0);
    check("add_fpu_start", 64'(fpu_start), 64'd1);
    check("add_busy", 64'(busy), 64'd1);
    check("add_op1", 64'(fpu_op1), 64'h3F80_0000);
    check("add_op2", 64'(fpu_op2), 64'h4000_0000);
    reply(3, 32'h4040_0000, 1'b0, 1'b0, 1'b0);
    check("add_busy_fall", 64'(busy), 64'd0);
    check("add_result", 64'(Result_Fpu), 64'h4040_0000);
    tick();
    check("add_busy_cycles", 64'(busy_cnt - b0), 64'd4);
    check("add_launches", 64'(fs_cnt - f0), 64'd1);
    check("add_irqs", 64'(irq_cnt - i0), 64'd1);
    check("add_valid_hold", 64'(Result_FPU_valid), 64'd1);

    // Illegal opcode: NaN one cycle after start, core untouched
    f0 = fs_cnt;
    exp_q.push_back({QNAN, 3'b001});
    pulse_start(32'h1234_5678, 32'h0, 3'd6);
    check("ill_result", 64'(Result_Fpu), 64'(QNAN));
    check("ill_busy", 64'(busy), 64'd0);
    check("ill_irq", 64'(done_irq), 64'd1);
    check("ill_op1_kept", 64'(fpu_op1), 64'h3F80_0000);
    repeat (2) tick();
    check("ill_no_launch", 64'(fs_cnt - f0), 64'd0);

    // Accepted start clears valid; start while busy sets overrun
    pulse_start(32'h40A0_0000, 32'h3F80_0000, 3'd2);
    check("mul_valid_cleared", 64'(Result_FPU_valid), 64'd0);
    tick();
    pulse_start(32'h4120_0000, 32'h0, 3'd0);
    check("ovr_set", 64'(overrun), 64'd1);
    check("ovr_op1_kept", 64'(fpu_op1), 64'h40A0_0000);
    check("ovr_op_kept", 64'(fpu_op), 64'd2);
    // done and start together in WAIT: completion wins, overrun stays set
    start = 1'b1;
    reply(0, 32'h40A0_0000, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    check("same_cyc_busy", 64'(busy), 64'd0);
    check("same_cyc_overrun", 64'(overrun), 64'd1);
    check("same_cyc_op1", 64'(fpu_op1), 64'h40A0_0000);

    // Next accepted start clears overrun; infinity flag passthrough at min latency
    pulse_start(32'h3F80_0000, 32'h0, 3'd3);
    check("ovr_cleared", 64'(overrun), 64'd0);
    check("div_op", 64'(fpu_op), 64'd3);
    reply(1, 32'h7F80_0000, 1'b0, 1'b1, 1'b0);
    check("inf_flags", 64'({zero_flag, INF_flag, NAN_flag}), 64'b010);
    tick();

    // Zero flag passthrough on sqrt
    pulse_start(32'h0, 32'h0, 3'd4);
    reply(2, 32'h0, 1'b1, 1'b0, 1'b0);
    check("zero_flags", 64'({zero_flag, INF_flag, NAN_flag}), 64'b100);
    tick();

`ifdef FPU_SEQ_TIMEOUT_EN
    // Core never answers: abort after 8 WAIT cycles
    exp_q.push_back({QNAN, 3'b001});
    pulse_start(32'h3F80_0000, 32'h3F80_0000, 3'd1);
    repeat (8) tick();
    check("to_still_busy", 64'(busy), 64'd1);
    check("to_not_yet", 64'(timeout_err), 64'd0);
    tick();
    check("to_busy_low", 64'(busy), 64'd0);
    check("to_err", 64'(timeout_err), 64'd1);
    check("to_nan", 64'(NAN_flag), 64'd1);
    tick();
    pulse_start(32'h3F80_0000, 32'h3F80_0000, 3'd1);
    check("to_err_cleared", 64'(timeout_err), 64'd0);
    reply(2, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
`else
    // No timeout build: WAIT holds indefinitely
    pulse_start(32'h3F80_0000, 32'h3F80_0000, 3'd1);
    repeat (20) tick();
    check("nto_busy", 64'(busy), 64'd1);
    check("nto_err", 64'(timeout_err), 64'd0);
    reply(0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
`endif

    // Reset during WAIT, late done ignored
    i0 = irq_cnt;
    pulse_start(32'h4000_0000, 32'h4000_0000, 3'd2);
    pulse_start(32'h4120_0000, 32'h0, 3'd0);
    check("rst_pre_overrun", 64'(overrun), 64'd1);
    RSTN = 1'b0;
    #1;
    check("rst_mid_outputs",
          64'({fpu_start, busy, Result_FPU_valid, zero_flag, INF_flag, NAN_flag, overrun, timeout_err, done_irq}),
          64'd0);
    check("rst_mid_ops", 64'({fpu_op1, fpu_op}), 64'd0);
    tick();
    RSTN = 1'b1;
    tick();
    fpu_done = 1'b1; fpu_result = 32'hDEAD_BEEF;
    tick();
    fpu_done = 1'b0;
    tick();
    check("late_done_valid", 64'(Result_FPU_valid), 64'd0);
    check("late_done_result", 64'(Result_Fpu), 64'd0);
    check("late_done_busy", 64'(busy), 64'd0);
    check("late_done_irq", 64'(irq_cnt - i0), 64'd0);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
